bsg_manycore_pkt_exec: RTL
==========================

Name: bsg_manycore_pkt_exec

Overview:
- Executes packets already classified by the manycore packet decoder.
- Sits directly downstream of the decoder and upstream of the tile's local data memory port.
- Owns the tile freeze register, a single-owner lock, and an unknown-packet error counter.
- Buffers one remote store in an output register with a valid/yumi handshake toward memory.

Parameters:
- x_cord_width_p, "inv", width of X coordinate
- y_cord_width_p, "inv", width of Y coordinate
- data_width_p, "inv", store data width; mask width is data_width_p>>3
- addr_width_p, "inv", word address width
- freeze_init_p, 1, freeze_o value at reset (tiles come up frozen)
- err_cnt_width_p, 8, width of the saturating unknown-packet counter

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- v_i  in  1  decoded packet valid (head of upstream FIFO)
- yumi_o  out  1  packet consumed this cycle; combinational from inputs and state
- pkt_freeze_i, pkt_unfreeze_i, pkt_unknown_i, lock_req_i, pkt_remote_store_i  in  1 each  decoder class flags
- data_i  in  data_width_p  packet data
- addr_i  in  addr_width_p  packet address
- mask_i  in  data_width_p>>3  byte mask
- from_x_cord_i  in  x_cord_width_p  sender X coordinate
- from_y_cord_i  in  y_cord_width_p  sender Y coordinate
- freeze_o  out  1  tile freeze state
- lock_held_o  out  1  lock currently owned
- lock_owner_x_o  out  x_cord_width_p  owner X coordinate; 0 when free
- lock_owner_y_o  out  y_cord_width_p  owner Y coordinate; 0 when free
- mem_v_o  out  1  store pending to memory
- mem_addr_o  out  addr_width_p  store address
- mem_data_o  out  data_width_p  store data
- mem_mask_o  out  data_width_p>>3  store byte mask
- mem_yumi_i  in  1  memory takes pending store; legal only when mem_v_o=1
- unknown_cnt_o  out  err_cnt_width_p  saturating count of unknown packets
- unknown_seen_o  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, immediate on assert):
  - freeze_o=freeze_init_p.
  - lock free; owner outputs 0.
  - mem_v_o=0; mem addr/data/mask outputs 0.
  - unknown_cnt_o=0; unknown_seen_o=0.
  - yumi_o=0 while reset_i=1.
  - Reset mid-store drops the pending store with no write to memory.
- Class resolution when v_i=1:
  - Priority: unknown > freeze/unfreeze > lock_req > remote_store.
  - v_i=1 with no flag set is treated as unknown.
  - yumi_o=0 whenever v_i=0.
- Unknown packet:
  - Always accepted.
  - Counter increments by 1 and saturates at all-ones.
  - unknown_seen_o set; it is sticky until reset.
- Freeze/unfreeze:
  - Always accepted.
  - freeze_o updates on the next edge.
  - Repeated freeze or unfreeze is idempotent.
- Lock FSM (FREE/HELD):
  - FREE + lock_req: accepted; go HELD; owner=from coordinates.
  - HELD + lock_req from owner: accepted; go FREE; owner outputs return to 0.
  - HELD + lock_req from non-owner: not accepted (yumi_o=0); packet stalls until the lock is released.
- Remote store:
  - Accepted iff output register is free, and either lock is FREE or sender equals owner.
  - Output register counts as free when mem_v_o=0, or when mem_v_o=1 and mem_yumi_i=1 in the same cycle (back-to-back stores at full throughput).
  - Accepted store appears on mem_* with mem_v_o=1 the next cycle (latency 1).
  - mem_* fields hold stable while mem_v_o=1 and mem_yumi_i=0.
  - Freeze state does not block stores (loader programs frozen tiles).
  - Stalled store: yumi_o=0; packet stays at upstream head.
- Output register:
  - mem_yumi_i with no new accepted store clears mem_v_o next cycle.
  - Simultaneous dequeue and accept loads the new store; mem_v_o stays 1.
- Non-store packets never touch the output register; they may be accepted while a store is pending.

Test Plan:
- Reset with freeze_init_p=1 -> freeze_o=1, mem_v_o=0, lock_held_o=0, unknown_cnt_o=0; unfreeze packet -> yumi_o=1, freeze_o=0 next cycle.
- Store addr=0x10, data=0xDEADBEEF, mask=4'b0011 with mem_yumi_i held 0 -> mem_v_o=1 next cycle with those fields; second store gets yumi_o=0 until mem_yumi_i=1, then loads in that same cycle, mem_v_o stays 1.
- Lock_req from (1,2) -> lock_held_o=1, owner=(1,2); store from (3,0) stalls; store from (1,2) accepted; lock_req from (1,2) -> lock free; stalled (3,0) store then accepted.
- Assert pkt_unknown_i for 300 packets with err_cnt_width_p=8 -> unknown_cnt_o=255, unknown_seen_o=1; all 300 accepted.
- Flags freeze+unknown together -> treated as unknown; freeze_o unchanged, counter +1.
- Assert reset_i mid-cycle with store pending and lock held -> mem_v_o, lock_held_o, and counter cleared immediately without a clock edge.

Source files
------------

// File: rtl/bsg_manycore_pkt_exec.sv
// bsg_manycore_pkt_exec
//   Executes decoded manycore packets: tile freeze register, single-owner
//   lock, saturating unknown-packet counter, and a one-entry remote-store
//   output register toward the tile data memory (valid/yumi).
// Ports:
//   clk_i, reset_i (async, active-high)
//   v_i / yumi_o            : decoded packet in / consumed
//   pkt_*_i, lock_req_i     : decoder class flags
//   data_i, addr_i, mask_i  : store payload
//   from_{x,y}_cord_i       : sender coordinates
//   freeze_o                : tile freeze state
//   lock_held_o, lock_owner_{x,y}_o : lock state, owner 0 when free
//   mem_{v,addr,data,mask}_o, mem_yumi_i : pending store toward memory
//   unknown_cnt_o, unknown_seen_o        : error reporting
module bsg_manycore_pkt_exec #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 10,
  parameter bit freeze_init_p   = 1'b1,
  parameter int err_cnt_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         yumi_o,
  input  logic                         pkt_freeze_i,
  input  logic                         pkt_unfreeze_i,
  input  logic                         pkt_unknown_i,
  input  logic                         lock_req_i,
  input  logic                         pkt_remote_store_i,
  input  logic [data_width_p-1:0]      data_i,
  input  logic [addr_width_p-1:0]      addr_i,
  input  logic [(data_width_p>>3)-1:0] mask_i,
  input  logic [x_cord_width_p-1:0]    from_x_cord_i,
  input  logic [y_cord_width_p-1:0]    from_y_cord_i,
  output logic                         freeze_o,
  output logic                         lock_held_o,
  output logic [x_cord_width_p-1:0]    lock_owner_x_o,
  output logic [y_cord_width_p-1:0]    lock_owner_y_o,
  output logic                         mem_v_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic [data_width_p-1:0]      mem_data_o,
  output logic [(data_width_p>>3)-1:0] mem_mask_o,
  input  logic                         mem_yumi_i,
  output logic [err_cnt_width_p-1:0]   unknown_cnt_o,
  output logic                         unknown_seen_o
);

  localparam int mask_width_lp = data_width_p >> 3;

  typedef enum logic {LOCK_FREE, LOCK_HELD} lock_state_e;

  lock_state_e                 lock_state_q, lock_state_d;
  logic                        freeze_q, freeze_d;
  logic [x_cord_width_p-1:0]   owner_x_q, owner_x_d;
  logic [y_cord_width_p-1:0]   owner_y_q, owner_y_d;
  logic                        mem_v_q, mem_v_d;
  logic [addr_width_p-1:0]     mem_addr_q, mem_addr_d;
  logic [data_width_p-1:0]     mem_data_q, mem_data_d;
  logic [mask_width_lp-1:0]    mem_mask_q, mem_mask_d;
  logic [err_cnt_width_p-1:0]  unknown_cnt_q, unknown_cnt_d;
  logic                        unknown_seen_q, unknown_seen_d;

  logic any_flag, is_unknown, is_freeze, is_lock, is_store;
  logic is_owner, out_free, lock_ok, accept;

  always_comb begin
    // Class resolution: a valid packet with no recognised flag is unknown.
    any_flag   = pkt_freeze_i | pkt_unfreeze_i | pkt_unknown_i
               | lock_req_i | pkt_remote_store_i;
    is_unknown = v_i & (pkt_unknown_i | ~any_flag);
    is_freeze  = v_i & ~is_unknown & (pkt_freeze_i | pkt_unfreeze_i);
    is_lock    = v_i & ~is_unknown & ~is_freeze & lock_req_i;
    is_store   = v_i & ~is_unknown & ~is_freeze & ~lock_req_i & pkt_remote_store_i;

    is_owner = (from_x_cord_i == owner_x_q) && (from_y_cord_i == owner_y_q);
    lock_ok  = (lock_state_q == LOCK_FREE) | is_owner;
    // Output register frees up in the same cycle memory dequeues it.
    out_free = ~mem_v_q | mem_yumi_i;

    accept = is_unknown | is_freeze
           | (is_lock & lock_ok)
           | (is_store & lock_ok & out_free);

    lock_state_d   = lock_state_q;
    freeze_d       = freeze_q;
    owner_x_d      = owner_x_q;
    owner_y_d      = owner_y_q;
    mem_v_d        = mem_v_q & ~mem_yumi_i;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    mem_mask_d     = mem_mask_q;
    unknown_cnt_d  = unknown_cnt_q;
    unknown_seen_d = unknown_seen_q;

    if (is_unknown) begin
      unknown_seen_d = 1'b1;
      if (unknown_cnt_q != '1)
        unknown_cnt_d = unknown_cnt_q + 1'b1;
    end

    // Freeze takes precedence if both freeze and unfreeze flags are set.
    if (is_freeze)
      freeze_d = pkt_freeze_i;

    if (is_lock & lock_ok) begin
      case (lock_state_q)
        LOCK_FREE: begin
          lock_state_d = LOCK_HELD;
          owner_x_d    = from_x_cord_i;
          owner_y_d    = from_y_cord_i;
        end
        default: begin
          lock_state_d = LOCK_FREE;
          owner_x_d    = '0;
          owner_y_d    = '0;
        end
      endcase
    end

    if (is_store & lock_ok & out_free) begin
      mem_v_d    = 1'b1;
      mem_addr_d = addr_i;
      mem_data_d = data_i;
      mem_mask_d = mask_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_state_q   <= LOCK_FREE;
      freeze_q       <= freeze_init_p;
      owner_x_q      <= '0;
      owner_y_q      <= '0;
      mem_v_q        <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_mask_q     <= '0;
      unknown_cnt_q  <= '0;
      unknown_seen_q <= 1'b0;
    end else begin
      lock_state_q   <= lock_state_d;
      freeze_q       <= freeze_d;
      owner_x_q      <= owner_x_d;
      owner_y_q      <= owner_y_d;
      mem_v_q        <= mem_v_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      mem_mask_q     <= mem_mask_d;
      unknown_cnt_q  <= unknown_cnt_d;
      unknown_seen_q <= unknown_seen_d;
    end
  end

  assign yumi_o         = ~reset_i & accept;
  assign freeze_o       = freeze_q;
  assign lock_held_o    = (lock_state_q == LOCK_HELD);
  assign lock_owner_x_o = owner_x_q;
  assign lock_owner_y_o = owner_y_q;
  assign mem_v_o        = mem_v_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign mem_mask_o     = mem_mask_q;
  assign unknown_cnt_o  = unknown_cnt_q;
  assign unknown_seen_o = unknown_seen_q;

endmodule
